// File: rtl/pid_controller_pipe.sv
// PID controller with run-time gains, fixed-point scaling, integrator clamp
// and a valid/ready sample handshake. One sample takes five clocks:
// IDLE -> ERR -> TERMS -> SUM -> DONE.
// Optional feature macro: PID_DERIV_EN builds the derivative path
// (prev_err, first flag, kd). Without it d=0 and kd is ignored.
module pid_controller_pipe #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned GAIN_W  = 8,
  parameter int unsigned FRAC_W  = 4,
  parameter int unsigned ACC_W   = 24,
  parameter int          INT_MAX = (1 << (ACC_W - 2)) - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] setpoint,
  input  logic [DATA_W-1:0] feedback,
  input  logic [GAIN_W-1:0] kp,
  input  logic [GAIN_W-1:0] ki,
  input  logic [GAIN_W-1:0] kd,
  output logic              out_valid,
  output logic [DATA_W-1:0] control_out,
  output logic              saturated
);

  localparam int unsigned EW = DATA_W + 1;      // error width
  localparam int unsigned PW = GAIN_W + 1 + EW; // gain * error product width
  localparam int unsigned SW = ACC_W + 2;       // final sum width

  localparam logic signed [ACC_W:0] IMAX    = (ACC_W + 1)'(INT_MAX);
  localparam logic signed [SW-1:0]  OUT_MAX = SW'((1 << DATA_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_TERMS, S_SUM, S_DONE} state_t;

  state_t state_q, state_d;

  logic        [DATA_W-1:0] sp_q, fb_q;
  logic        [GAIN_W-1:0] kp_q, ki_q;
  logic signed [EW-1:0]     err_q, err_c;
  logic signed [ACC_W-1:0]  p_q, integ_q;
  logic signed [PW-1:0]     p_prod_c, i_prod_c;
  logic signed [ACC_W:0]    i_sum_c;
  logic signed [ACC_W-1:0]  i_next_c;
  logic signed [SW-1:0]     sum_c, shift_c;

`ifdef PID_DERIV_EN
  localparam int unsigned DW  = EW + 1;         // error difference width
  localparam int unsigned DPW = GAIN_W + 1 + DW;

  logic        [GAIN_W-1:0] kd_q;
  logic signed [EW-1:0]     prev_err_q;
  logic                     first_q;
  logic signed [ACC_W-1:0]  d_q, d_c;
  logic signed [DW-1:0]     diff_c;
  logic signed [DPW-1:0]    d_prod_c;
`else
  logic unused_kd;
  assign unused_kd = ^kd;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake ready; clear always forces IDLE
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = !clear;
        if (in_valid && !clear) state_d = S_ERR;
      end
      S_ERR:   state_d = S_TERMS;
      S_TERMS: state_d = S_SUM;
      S_SUM:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear) state_d = S_IDLE;
  end

  // Error, term products, clamped integrator and scaled sum
  always_comb begin
    err_c    = $signed({1'b0, sp_q}) - $signed({1'b0, fb_q});
    p_prod_c = PW'($signed({1'b0, kp_q})) * PW'(err_q);
    i_prod_c = PW'($signed({1'b0, ki_q})) * PW'(err_q);
    i_sum_c  = (ACC_W + 1)'(integ_q) + (ACC_W + 1)'(i_prod_c);
    if (i_sum_c > IMAX)       i_next_c = ACC_W'(IMAX);
    else if (i_sum_c < -IMAX) i_next_c = ACC_W'(-IMAX);
    else                      i_next_c = ACC_W'(i_sum_c);
`ifdef PID_DERIV_EN
    diff_c   = DW'(err_q) - DW'(prev_err_q);
    d_prod_c = DPW'($signed({1'b0, kd_q})) * DPW'(diff_c);
    d_c      = first_q ? '0 : ACC_W'(d_prod_c);
    sum_c    = SW'(p_q) + SW'(integ_q) + SW'(d_q);
`else
    sum_c    = SW'(p_q) + SW'(integ_q);
`endif
    shift_c  = sum_c >>> FRAC_W;
  end

  // Datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q        <= '0;
      fb_q        <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      err_q       <= '0;
      p_q         <= '0;
      integ_q     <= '0;
      out_valid   <= 1'b0;
      control_out <= '0;
      saturated   <= 1'b0;
`ifdef PID_DERIV_EN
      kd_q        <= '0;
      d_q         <= '0;
      prev_err_q  <= '0;
      first_q     <= 1'b1;
`endif
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        integ_q    <= '0;
`ifdef PID_DERIV_EN
        prev_err_q <= '0;
        first_q    <= 1'b1;
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
            if (in_valid) begin
              sp_q <= setpoint;
              fb_q <= feedback;
              kp_q <= kp;
              ki_q <= ki;
`ifdef PID_DERIV_EN
              kd_q <= kd;
`endif
            end
          end
          S_ERR: err_q <= err_c;
          S_TERMS: begin
            p_q     <= ACC_W'(p_prod_c);
            integ_q <= i_next_c;
`ifdef PID_DERIV_EN
            d_q     <= d_c;
`endif
          end
          S_SUM: begin
            out_valid <= 1'b1;
            if (shift_c[SW-1]) begin
              control_out <= '0;
              saturated   <= 1'b1;
            end else if (shift_c > OUT_MAX) begin
              control_out <= '1;
              saturated   <= 1'b1;
            end else begin
              control_out <= shift_c[DATA_W-1:0];
              saturated   <= 1'b0;
            end
          end
          S_DONE: begin
`ifdef PID_DERIV_EN
            prev_err_q <= err_q;
            first_q    <= 1'b0;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pid_controller_pipe.sv
// Self-checking bench for pid_controller_pipe (INT_MAX=1000 instance).
// Vector table plus hand-written handshake, clear and reset sequences;
// expected outputs go through a scoreboard queue popped on out_valid.
module tb_pid_controller_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] setpoint = '0, feedback = '0, kp = '0, ki = '0, kd = '0;
  logic       out_valid;
  logic [7:0] control_out;
  logic       saturated;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] out;
    logic       sat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       clr;
    logic [7:0] sp, fb, kp, ki, kd;
    logic [7:0] exp_out;
    logic       exp_sat;
  } vec_t;

`ifdef PID_DERIV_EN
  localparam logic [7:0] D2 = 8'd20;
`else
  localparam logic [7:0] D2 = 8'd0;
`endif

  pid_controller_pipe #(
    .DATA_W(8), .GAIN_W(8), .FRAC_W(4), .ACC_W(24), .INT_MAX(1000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .setpoint(setpoint), .feedback(feedback),
    .kp(kp), .ki(ki), .kd(kd),
    .out_valid(out_valid), .control_out(control_out), .saturated(saturated)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every out_valid pulse must match the oldest pending result
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("control_out", 32'(control_out), 32'(e.out));
        check("saturated", 32'(saturated), 32'(e.sat));
      end
    end
  end

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic drive(input logic [7:0] s, input logic [7:0] f,
                       input logic [7:0] p, input logic [7:0] i, input logic [7:0] d);
    setpoint = s; feedback = f; kp = p; ki = i; kd = d;
  endtask

  // Offer one sample, push its expectation at accept, check latency and pulse width
  task automatic send(input logic [7:0] s, input logic [7:0] f, input logic [7:0] p,
                      input logic [7:0] i, input logic [7:0] d,
                      input logic [7:0] eo, input logic es);
    int n;
    exp_t e;
    @(negedge clk);
    drive(s, f, p, i, d);
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      e.out = eo;
      e.sat = es;
      sb.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("out_valid_latency", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1 check("out_valid_pulse", 32'(out_valid), 32'd0);
    end
  endtask

  vec_t vecs[14];

  initial begin
    int acc_cyc[$];
    int low_cnt;

    vecs[0]  = '{1'b1, 8'd100, 8'd60, 8'h20, 8'h00, 8'h00, 8'd80,  1'b0};
    vecs[1]  = '{1'b1, 8'd200, 8'd0,  8'h20, 8'h00, 8'h00, 8'd255, 1'b1};
    vecs[2]  = '{1'b1, 8'd0,   8'd50, 8'h20, 8'h00, 8'h00, 8'd0,   1'b1};
    vecs[3]  = '{1'b1, 8'd50,  8'd30, 8'h18, 8'h08, 8'h00, 8'd40,  1'b0};
    vecs[4]  = '{1'b1, 8'd10,  8'd0,  8'h00, 8'h10, 8'h00, 8'd10,  1'b0};
    vecs[5]  = '{1'b0, 8'd10,  8'd0,  8'h00, 8'h10, 8'h00, 8'd20,  1'b0};
    vecs[6]  = '{1'b0, 8'd10,  8'd0,  8'h00, 8'h10, 8'h00, 8'd30,  1'b0};
    vecs[7]  = '{1'b0, 8'd10,  8'd0,  8'h00, 8'h10, 8'h00, 8'd40,  1'b0};
    vecs[8]  = '{1'b0, 8'd10,  8'd0,  8'h00, 8'h10, 8'h00, 8'd50,  1'b0};
    vecs[9]  = '{1'b0, 8'd10,  8'd0,  8'h00, 8'h10, 8'h00, 8'd60,  1'b0};
    vecs[10] = '{1'b0, 8'd10,  8'd0,  8'h00, 8'h10, 8'h00, 8'd62,  1'b0};
    vecs[11] = '{1'b1, 8'd10,  8'd0,  8'h00, 8'h00, 8'h10, 8'd0,   1'b0};
    vecs[12] = '{1'b0, 8'd30,  8'd0,  8'h00, 8'h00, 8'h10, D2,     1'b0};
    vecs[13] = '{1'b1, 8'd60,  8'd50, 8'h10, 8'h00, 8'h00, 8'd10,  1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_control_out", 32'(control_out), 32'd0);
    check("rst_saturated", 32'(saturated), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].clr) do_clear();
      send(vecs[v].sp, vecs[v].fb, vecs[v].kp, vecs[v].ki, vecs[v].kd,
           vecs[v].exp_out, vecs[v].exp_sat);
    end

    // in_valid held high: one accept every 5 cycles, in_ready low in between
    do_clear();
    @(negedge clk);
    drive(8'd5, 8'd0, 8'h10, 8'h00, 8'h00);
    in_valid = 1'b1;
    low_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (in_ready) begin
        exp_t e;
        e.out = 8'd5;
        e.sat = 1'b0;
        sb.push_back(e);
        acc_cyc.push_back(c);
      end else begin
        low_cnt++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("hold_accept_count", 32'(acc_cyc.size()), 32'd4);
    check("hold_ready_low", 32'(low_cnt), 32'd16);
    for (int k = 1; k < acc_cyc.size(); k++)
      check("hold_accept_gap", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd5);
    repeat (6) @(negedge clk);

    // clear together with in_valid: no accept, integrator zeroed
    do_clear();
    send(8'd10, 8'd0, 8'h00, 8'h10, 8'h00, 8'd10, 1'b0);
    @(negedge clk);
    drive(8'd10, 8'd0, 8'h00, 8'h10, 8'h00);
    in_valid = 1'b1;
    clear = 1'b1;
    #1 check("clear_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b0;
    #1 check("clear_still_idle", 32'(in_ready), 32'd1);
    repeat (6) @(negedge clk);
    send(8'd10, 8'd0, 8'h00, 8'h10, 8'h00, 8'd10, 1'b0);

    // Reset while in TERMS: no pulse, reset values, next sample treated as first
    do_clear();
    send(8'd10, 8'd0, 8'h10, 8'h00, 8'h10, 8'd10, 1'b0);
    @(negedge clk);
    drive(8'd30, 8'd0, 8'h10, 8'h00, 8'h10);
    in_valid = 1'b1;
    #1;
    if (!in_ready) check("rst_seq_ready", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_control_out", 32'(control_out), 32'd0);
    check("midrst_saturated", 32'(saturated), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    send(8'd30, 8'd0, 8'h00, 8'h00, 8'h10, 8'd0, 1'b0);

    repeat (8) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time guard
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
